// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals shared by the arbiter.
// The slave modport is the arbiter side; the master modport is the CPU/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_rdata, if_ack, ls_rdata, ls_ack, mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_rdata, if_ack, ls_rdata, ls_ack, mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store (IDLE -> ACCESS -> ACK).
// Define MEM_ARB_RR_EN for round-robin priority; default is fixed load/store-first priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_gnt_ls;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;
  logic              w_any;
  logic              w_pick_ls;
  logic              w_grant;
  logic              w_last_beat;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_if_ack;
  logic              w_ls_ack;

  assign w_any       = bus.if_req | bus.ls_req;
  assign w_grant     = (r_state == S_IDLE) && w_any;
  assign w_last_beat = (r_state == S_ACCESS) && (r_cnt == 4'd0);

`ifdef MEM_ARB_RR_EN
  logic r_last_ls;

  // Remembers which requester won most recently so a tie goes to the other one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_ls <= 1'b0;
    end else if (w_grant) begin
      r_last_ls <= w_pick_ls;
    end else begin
      r_last_ls <= r_last_ls;
    end
  end

  assign w_pick_ls = bus.ls_req & (~bus.if_req | ~r_last_ls);
`else
  // The load/store belongs to the older instruction, so it always wins a tie.
  assign w_pick_ls = bus.ls_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = S_ACCESS;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_next = S_ACK;
        end else begin
          w_next = S_ACCESS;
        end
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant capture: the memory-side address/data are frozen for the whole access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 4'd0;
      r_gnt_ls <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= {ADDR_W{1'b0}};
      r_wdata  <= {DATA_W{1'b0}};
    end else if (w_grant) begin
      r_cnt    <= LAT_M1;
      r_gnt_ls <= w_pick_ls;
      r_we     <= w_pick_ls & bus.ls_we;
      r_addr   <= w_pick_ls ? bus.ls_addr : bus.if_addr;
      r_wdata  <= w_pick_ls ? bus.ls_wdata : {DATA_W{1'b0}};
    end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if_rdata <= {DATA_W{1'b0}};
      r_ls_rdata <= {DATA_W{1'b0}};
    end else if (w_last_beat && !r_we) begin
      if (r_gnt_ls) begin
        r_ls_rdata <= bus.mem_rdata;
      end else begin
        r_if_rdata <= bus.mem_rdata;
      end
    end else begin
      r_if_rdata <= r_if_rdata;
      r_ls_rdata <= r_ls_rdata;
    end
  end

  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = {ADDR_W{1'b0}};
    w_mem_wdata = {DATA_W{1'b0}};
    w_if_ack    = 1'b0;
    w_ls_ack    = 1'b0;
    case (r_state)
      S_ACCESS: begin
        w_mem_en    = 1'b1;
        w_mem_we    = r_we;
        w_mem_addr  = r_addr;
        w_mem_wdata = r_wdata;
      end
      S_ACK: begin
        if (r_gnt_ls) begin
          w_ls_ack = 1'b1;
        end else begin
          w_if_ack = 1'b1;
        end
      end
      default: begin
        w_mem_en = 1'b0;
      end
    endcase
  end

  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.if_ack    = w_if_ack;
  assign bus.ls_ack    = w_ls_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.stall     = (bus.if_req & ~w_if_ack) | (bus.ls_req & ~w_ls_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a MEM_LAT=2 instance for the functional tests and a
// MEM_LAT=1 instance for back-to-back throughput; ack responses are checked by monitors.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    bit          is_ls;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (.clk(clk), .reset(reset), .bus(a.slave));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    case (addr)
      32'h40:  mem_model = 32'h2000_0001;
      32'h44:  mem_model = 32'h2000_0002;
      32'h20:  mem_model = 32'h1234_5678;
      default: mem_model = {16'hA5A5, addr[15:0]};
    endcase
  endfunction

  assign a.mem_rdata = mem_model(a.mem_addr);
  assign b.mem_rdata = mem_model(b.mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ack monitor for the MEM_LAT=2 instance.
  always @(negedge clk) begin
    if (a.if_ack || a.ls_ack) begin
      chk("one_ack", {31'd0, a.if_ack & a.ls_ack}, 32'd0);
      if (q0.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("ack_kind", {31'd0, a.ls_ack}, {31'd0, e.is_ls});
        chk("ack_cycle", cyc, e.at);
        chk("ack_rdata", e.is_ls ? a.ls_rdata : a.if_rdata, e.data);
      end
    end
  end

  // Ack monitor for the MEM_LAT=1 instance.
  always @(negedge clk) begin
    if (b.if_ack || b.ls_ack) begin
      if (q1.size() == 0) begin
        chk("unexpected_ack1", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("ack1_kind", {31'd0, b.ls_ack}, {31'd0, e.is_ls});
        chk("ack1_cycle", cyc, e.at);
        chk("ack1_rdata", b.if_rdata, e.data);
      end
    end
  end

  task automatic push0(input bit is_ls, input logic [31:0] data, input int at);
    exp_t e;
    e.is_ls = is_ls;
    e.data  = data;
    e.at    = at;
    q0.push_back(e);
  endtask

  // Single transaction on the MEM_LAT=2 port; starts and ends at posedge+1 in IDLE.
  task automatic single(input bit is_ls, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data);
    int t0;
    if (is_ls) begin
      a.ls_req = 1'b1; a.ls_we = we; a.ls_addr = addr; a.ls_wdata = wdata;
    end else begin
      a.if_req = 1'b1; a.if_addr = addr;
    end
    t0 = cyc;
    push0(is_ls, exp_data, t0 + 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("idle_mem_en", {31'd0, a.mem_en}, 32'd0);
        chk("stall_wait", {31'd0, a.stall}, 32'd1);
      end else if (k < 3) begin
        chk("acc_mem_en", {31'd0, a.mem_en}, 32'd1);
        chk("acc_mem_we", {31'd0, a.mem_we}, {31'd0, we});
        chk("acc_mem_addr", a.mem_addr, addr);
        if (we) chk("acc_mem_wdata", a.mem_wdata, wdata);
        chk("stall_acc", {31'd0, a.stall}, 32'd1);
      end else begin
        chk("ack_mem_en", {31'd0, a.mem_en}, 32'd0);
        chk("ack_mem_we", {31'd0, a.mem_we}, 32'd0);
        chk("stall_ack", {31'd0, a.stall}, 32'd0);
      end
    end
    @(posedge clk); #1;
    a.if_req = 1'b0;
    a.ls_req = 1'b0;
    a.ls_we  = 1'b0;
  endtask

  task automatic wait_drop(input bit is_ls);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      seen = is_ls ? a.ls_ack : a.if_ack;
    end
    if (!seen) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (is_ls) a.ls_req = 1'b0;
    else       a.if_req = 1'b0;
  endtask

  initial begin
    int t0;
    int en_cnt;
    {a.if_req, a.ls_req, a.ls_we} = 3'b000;
    a.if_addr = 32'd0; a.ls_addr = 32'd0; a.ls_wdata = 32'd0;
    {b.if_req, b.ls_req, b.ls_we} = 3'b000;
    b.if_addr = 32'd0; b.ls_addr = 32'd0; b.ls_wdata = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", {31'd0, a.mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, a.mem_we}, 32'd0);
    chk("rst_mem_addr", a.mem_addr, 32'd0);
    chk("rst_mem_wdata", a.mem_wdata, 32'd0);
    chk("rst_if_rdata", a.if_rdata, 32'd0);
    chk("rst_ls_rdata", a.ls_rdata, 32'd0);
    chk("rst_acks", {30'd0, a.if_ack, a.ls_ack}, 32'd0);
    chk("rst_stall_low", {31'd0, a.stall}, 32'd0);
    a.if_req = 1'b1;
    #1 chk("rst_stall_follows", {31'd0, a.stall}, 32'd1);
    a.if_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    single(1'b0, 1'b0, 32'h40, 32'd0, 32'h2000_0001);
    single(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0000_0000);
    single(1'b1, 1'b0, 32'h20, 32'd0, 32'h1234_5678);

    // Simultaneous fetch 0x44 and load 0x20; the previous grant was a load.
    a.if_req = 1'b1; a.if_addr = 32'h44;
    a.ls_req = 1'b1; a.ls_we = 1'b0; a.ls_addr = 32'h20;
    t0 = cyc;
`ifdef MEM_ARB_RR_EN
    push0(1'b0, 32'h2000_0002, t0 + 3);
    push0(1'b1, 32'h1234_5678, t0 + 7);
    wait_drop(1'b0);
    wait_drop(1'b1);
`else
    push0(1'b1, 32'h1234_5678, t0 + 3);
    push0(1'b0, 32'h2000_0002, t0 + 7);
    wait_drop(1'b1);
    wait_drop(1'b0);
`endif

    // Reset in the second ACCESS cycle of a fetch, then restart with the request held.
    a.if_req = 1'b1; a.if_addr = 32'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_mem_en", {31'd0, a.mem_en}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_mem_en", {31'd0, a.mem_en}, 32'd0);
    chk("mid_rst_mem_we", {31'd0, a.mem_we}, 32'd0);
    chk("mid_rst_if_rdata", a.if_rdata, 32'd0);
    chk("mid_rst_ls_rdata", a.ls_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    push0(1'b0, 32'h2000_0002 - 32'd1, cyc + 3);
    wait_drop(1'b0);

    // MEM_LAT=1 with a continuous fetch request: ack every third cycle.
    b.if_req = 1'b1; b.if_addr = 32'h44;
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.is_ls = 1'b0;
      e.data  = 32'h2000_0002;
      e.at    = t0 + 2 + 3 * i;
      q1.push_back(e);
    end
    en_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (b.mem_en) en_cnt++;
    end
    @(posedge clk); #1;
    b.if_req = 1'b0;
    chk("lat1_mem_en_duty", en_cnt, 32'd3);

    repeat (3) @(posedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
